// File: rtl/fp_addsub_pipe_if.sv
// fp_addsub_pipe_if: operand/result handshake bundle for fp_addsub_pipe
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_valid, in_ready, sub, out_valid, out_ready, overflow, underflow, invalid;
  logic [W-1:0] a, b, s;
  modport master (
    output in_valid, a, b, sub, out_ready,
    input in_ready, out_valid, s, overflow, underflow, invalid
  );
  modport slave (
    input in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: pipelined IEEE-754 add/subtract, RNE, flush-to-zero, valid/ready
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst_n,
  fp_addsub_pipe_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int N = MAN_W + 4;
  localparam int SW = $clog2(N + 1);
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0] INF = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  logic adv, v0, v1, v2, v3;
  assign adv = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;
  logic [W-1:0] a0, b0;
  logic sub0;
  logic sa, sb, za, zb, ia, ib, na, nb, swap, sp_c, inv_c;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic [W-1:0] sv_c;
  // unpack: classify operands, order by magnitude, resolve special results early
  always_comb begin
    {sa, ea, ma} = a0;
    {eb, mb} = b0[W-2:0];
    sb = b0[W-1] ^ sub0;
    za = ea == '0;
    zb = eb == '0;
    ia = &ea && ma == '0;
    ib = &eb && mb == '0;
    na = &ea && |ma;
    nb = &eb && |mb;
    swap = (zb ? '0 : b0[W-2:0]) > (za ? '0 : a0[W-2:0]);
    inv_c = ia && ib && sa != sb;
    sp_c = na || nb || ia || ib || (za && zb);
    sv_c = (na || nb || inv_c) ? QNAN : ia ? {sa, INF} : ib ? {sb, INF} : {sa & sb, {(W-1){1'b0}}};
  end
  logic sp1, inv1, sg1, op1;
  logic [W-1:0] sv1;
  logic [EXP_W-1:0] e1, d1;
  logic [MAN_W:0] big1, sml1;
  logic [SW-1:0] sh;
  logic [2*N-1:0] wide;
  logic [N-1:0] al;
  assign sh = 32'(d1) > 32'(N - 1) ? SW'(N - 1) : SW'(d1);
  assign wide = {sml1, {(N+3){1'b0}}} >> sh;
  assign al = {wide[2*N-1:N+1], wide[N] | (|wide[N-1:0])};
  logic sp2, inv2, sg2, op2;
  logic [W-1:0] sv2;
  logic [EXP_W-1:0] e2;
  logic [N-1:0] big2, sml2;
  logic [N:0] sum;
  logic [SW-1:0] lz;
  assign sum = op2 ? {1'b0, big2} - {1'b0, sml2} : {1'b0, big2} + {1'b0, sml2};
  // leading-zero count of the sum below the carry bit; N when the sum is zero
  always_comb begin
    lz = SW'(N);
    for (int i = 0; i < N; i++) lz = sum[i] ? SW'(N - 1 - i) : lz;
  end
  logic sp3, inv3, sg3;
  logic [W-1:0] sv3;
  logic [EXP_W-1:0] e3;
  logic [N:0] sum3;
  logic [SW-1:0] lz3;
  logic [N-1:0] nrm;
  logic signed [31:0] en, ef;
  logic up, cy, ovf, unf;
  logic [MAN_W-1:0] frac;
  logic [W-1:0] res;
  // normalise, round to nearest even, detect overflow/underflow and pack
  always_comb begin
    nrm = sum3[N] ? {sum3[N:2], sum3[1] | sum3[0]} : sum3[N-1:0] << lz3;
    en = sum3[N] ? $signed(32'(e3)) + 32'sd1 : $signed(32'(e3)) - $signed(32'(lz3));
    up = nrm[2] && (nrm[1] || nrm[0] || nrm[3]);
    {cy, frac} = {1'b0, nrm[N-2:3]} + (MAN_W+1)'(up);
    ef = en + (cy ? 32'sd1 : 32'sd0);
    unf = !sp3 && nrm[N-1] && en <= 0;
    ovf = !sp3 && nrm[N-1] && !unf && ef >= EMAX;
    res = sp3 ? sv3 : !nrm[N-1] ? '0 : unf ? {sg3, {(W-1){1'b0}}} : ovf ? {sg3, INF} : {sg3, ef[EXP_W-1:0], frac};
  end
  // stage valid bits and result register, all advancing together on adv
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v0, v1, v2, v3, io.out_valid} <= '0;
      {io.s, io.overflow, io.underflow, io.invalid} <= '0;
    end else if (adv) begin
      {v0, v1, v2, v3, io.out_valid} <= {io.in_valid, v0, v1, v2, v3};
      io.s <= res;
      io.overflow <= ovf;
      io.underflow <= unf;
      io.invalid <= sp3 && inv3;
    end
  // datapath registers; their contents matter only where the matching valid bit is set
  always_ff @(posedge clk)
    if (adv) begin
      {a0, b0, sub0} <= {io.a, io.b, io.sub};
      {sp1, inv1, sv1} <= {sp_c, inv_c, sv_c};
      sg1 <= swap ? sb : sa;
      op1 <= sa ^ sb;
      e1 <= swap ? eb : ea;
      d1 <= swap ? eb - ea : ea - eb;
      big1 <= swap ? {1'b1, mb} : {1'b1, ma};
      sml1 <= swap ? (za ? '0 : {1'b1, ma}) : (zb ? '0 : {1'b1, mb});
      {sp2, inv2, sv2, sg2, op2, e2} <= {sp1, inv1, sv1, sg1, op1, e1};
      big2 <= {big1, 3'b000};
      sml2 <= al;
      {sp3, inv3, sv3, sg3, e3} <= {sp2, inv2, sv2, sg2, e2};
      sum3 <= sum;
      lz3 <= lz;
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed checks of fp_addsub_pipe in binary32 and binary16
module tb_fp_addsub_pipe;
  logic clk = 0, rst_n = 0;
  int errors = 0, checks = 0;
  int k;
  bit stall, seen;
  logic [31:0] held;
  logic [31:0] bp_a [8] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h41200000,
                            32'hBF800000, 32'h3F000000, 32'h40800000, 32'h42C80000};
  logic [31:0] bp_b [8] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40A00000,
                            32'hBF800000, 32'h3F000000, 32'h41000000, 32'h3F800000};
  logic bp_sub [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] bp_s [8] = '{32'h40400000, 32'h40000000, 32'h40C00000, 32'h40A00000,
                            32'hC0000000, 32'h3F800000, 32'hC0800000, 32'h42CA0000};
  always #5 clk = ~clk;
  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) io32 ();
  fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) io16 ();
  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .io(io32.slave));
  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .io(io16.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // one operation with out_ready high; flags expected as {overflow, underflow, invalid}
  task automatic op(input bit h, input logic [31:0] a, input logic [31:0] b, input logic sub,
                    input logic [31:0] es, input logic [2:0] ef, input string tag);
    @(posedge clk); #1;
    if (h) begin
      io16.a = a[15:0]; io16.b = b[15:0]; io16.sub = sub; io16.in_valid = 1;
    end else begin
      io32.a = a; io32.b = b; io32.sub = sub; io32.in_valid = 1;
    end
    @(posedge clk); #1;
    io16.in_valid = 0; io32.in_valid = 0;
    repeat (3) @(posedge clk);
    #1 check({tag, "_early"}, h ? io16.out_valid : io32.out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, h ? io16.out_valid : io32.out_valid, 1);
    check({tag, "_s"}, h ? {48'b0, io16.s} : {32'b0, io32.s}, {32'b0, es});
    check({tag, "_flags"}, h ? {io16.overflow, io16.underflow, io16.invalid}
                             : {io32.overflow, io32.underflow, io32.invalid}, ef);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    {io32.in_valid, io32.sub, io32.a, io32.b} = '0; io32.out_ready = 1;
    {io16.in_valid, io16.sub, io16.a, io16.b} = '0; io16.out_ready = 1;
    #12;
    check("rst_valid", io32.out_valid, 0);
    check("rst_s", io32.s, 0);
    check("rst_flags", {io32.overflow, io32.underflow, io32.invalid}, 0);
    check("rst_valid16", io16.out_valid, 0);
    @(negedge clk) rst_n = 1;
    #1 check("rst_in_ready", io32.in_ready, 1);
    op(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'b000, "add_1_2");
    op(0, 32'h40400000, 32'h3F800000, 1, 32'h40000000, 3'b000, "sub_3_1");
    op(0, 32'hC0000000, 32'h40000000, 0, 32'h00000000, 3'b000, "cancel");
    op(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 3'b000, "rne_tie");
    op(0, 32'h3F800000, 32'h33800001, 0, 32'h3F800001, 3'b000, "rne_up");
    op(0, 32'h7F7FFFFF, 32'h3F800000, 0, 32'h7F7FFFFF, 3'b000, "max_plus_1");
    op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 3'b100, "overflow");
    op(0, 32'h00800000, 32'h00800001, 1, 32'h80000000, 3'b010, "underflow");
    op(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 3'b001, "inf_minus_inf");
    op(0, 32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 3'b000, "nan_in");
    op(0, 32'h3F800000, 32'h7F800000, 1, 32'hFF800000, 3'b000, "fin_minus_inf");
    op(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 3'b000, "negz_plus_negz");
    op(0, 32'h80000000, 32'h80000000, 1, 32'h00000000, 3'b000, "negz_minus_negz");
    op(1, 32'h3C00, 32'h4000, 0, 32'h4200, 3'b000, "h_add_1_2");
    op(1, 32'h3C00, 32'h1000, 0, 32'h3C00, 3'b000, "h_rne_tie");
    op(1, 32'h3C00, 32'h1001, 0, 32'h3C01, 3'b000, "h_rne_up");
    op(1, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, 3'b100, "h_overflow");
    op(1, 32'h0400, 32'h0401, 1, 32'h8000, 3'b010, "h_underflow");
    op(1, 32'h7C00, 32'hFC00, 0, 32'h7E00, 3'b001, "h_inf_minus_inf");
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      io32.a = bp_a[i]; io32.b = bp_b[i]; io32.sub = bp_sub[i]; io32.in_valid = 1;
      @(posedge clk); #1;
    end
    io32.in_valid = 0;
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    check("midrst_valid", io32.out_valid, 0);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | io32.out_valid;
    end
    check("midrst_no_stale", seen, 0);
    k = 0; stall = 0; held = '0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          io32.a = bp_a[i]; io32.b = bp_b[i]; io32.sub = bp_sub[i]; io32.in_valid = 1;
          @(negedge clk);
          for (int t = 0; t < 20 && !io32.in_ready; t++) @(negedge clk);
          @(posedge clk); #1;
        end
        io32.in_valid = 0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          io32.out_ready = (c < 5) ? 1'b1 : (c < 8) ? 1'b0 : c[0];
          @(posedge clk); #1;
        end
        io32.out_ready = 1;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          check("in_ready_adv", io32.in_ready, !(io32.out_valid && !io32.out_ready));
          if (stall && io32.out_valid) check("stall_hold", io32.s, held);
          if (io32.out_valid && io32.out_ready) begin
            if (k < 8) check($sformatf("bp_res%0d", k), io32.s, bp_s[k]);
            k++;
          end
          stall = io32.out_valid && !io32.out_ready;
          held = io32.s;
        end
      end
    join
    check("bp_count", k, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
